// File: rtl/i281_pkg.sv
// Shared i281 definitions: data-memory default geometry and the scan-port state type.
package i281_pkg;
  localparam int I281_DWIDTH = 8;
  localparam int I281_DDEPTH = 16;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_BUSY,
    SCAN_DONE
  } scan_state_t;
endpackage

// File: rtl/i281_scan_fsm.sv
// Scan-out sequencer for the data memory: walks every index once under a valid/ready
// handshake and pulses scan_done after the last word. Runs regardless of the core run gate.
module i281_scan_fsm
  import i281_pkg::*;
#(
  parameter int DEPTH  = I281_DDEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scan_start,
  input  logic              scan_ready,
  output logic              scan_valid,
  output logic [ADDR_W-1:0] scan_idx,
  output logic              scan_done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  scan_state_t state;

  // scan_valid is high exactly while BUSY, so a handshake reduces to scan_ready
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= SCAN_IDLE;
      scan_valid <= 1'b0;
      scan_idx   <= '0;
      scan_done  <= 1'b0;
    end else begin
      case (state)
        SCAN_IDLE: begin
          if (scan_start) begin
            state      <= SCAN_BUSY;
            scan_valid <= 1'b1;
            scan_idx   <= '0;
          end
        end
        SCAN_BUSY: begin
          if (scan_ready) begin
            if (scan_idx == LAST) begin
              state      <= SCAN_DONE;
              scan_valid <= 1'b0;
              scan_done  <= 1'b1;
              scan_idx   <= '0;
            end else begin
              scan_idx <= scan_idx + 1'b1;
            end
          end
        end
        SCAN_DONE: begin
          state     <= SCAN_IDLE;
          scan_done <= 1'b0;
        end
        default: begin
          state      <= SCAN_IDLE;
          scan_valid <= 1'b0;
          scan_done  <= 1'b0;
          scan_idx   <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/i281_datamem_n.sv
// Parametrised i281 data memory with internal read-data register and flattened dump bus.
// Define DMEM_SCAN_EN to build the valid/ready scan-out port; otherwise scan outputs are 0.
module i281_datamem_n
  import i281_pkg::*;
#(
  parameter int WIDTH  = I281_DWIDTH,
  parameter int DEPTH  = I281_DDEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rdata,
  output logic [WIDTH-1:0]       rdata_q,
  output logic [DEPTH*WIDTH-1:0] dump,
  input  logic                   scan_start,
  output logic                   scan_valid,
  input  logic                   scan_ready,
  output logic [WIDTH-1:0]       scan_data,
  output logic [ADDR_W-1:0]      scan_idx,
  output logic                   scan_done
);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        in_range;

  // Non-power-of-two depths leave a hole in the address space: reads 0, writes dropped
  assign in_range = {1'b0, addr} < DEPTH_A;
  assign rdata    = in_range ? mem[addr] : '0;
  assign dump     = mem;

  // rdata_q samples the pre-edge array, giving read-before-write on a shared address
  always_ff @(posedge clock) begin
    if (reset) begin
      mem     <= '0;
      rdata_q <= '0;
    end else if (run) begin
      if (rd_en) rdata_q <= rdata;
      if (we && in_range) mem[addr] <= wdata;
    end
  end

`ifdef DMEM_SCAN_EN
  i281_scan_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clock      (clock),
    .reset      (reset),
    .scan_start (scan_start),
    .scan_ready (scan_ready),
    .scan_valid (scan_valid),
    .scan_idx   (scan_idx),
    .scan_done  (scan_done)
  );

  assign scan_data = mem[scan_idx];
`else
  logic scan_unused;
  assign scan_unused = scan_start | scan_ready;
  assign scan_valid  = 1'b0;
  assign scan_data   = '0;
  assign scan_idx    = '0;
  assign scan_done   = 1'b0;
`endif
endmodule

// File: tb/tb_i281_datamem_n.sv
// Self-checking bench for i281_datamem_n: a 16-word and a 12-word instance share stimulus
// and are compared every cycle against an array-based reference model.
module tb_i281_datamem_n;
  logic        clock = 1'b0;
  logic        reset, run, we, rd_en, scan_start, scan_ready;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic        zero_l = 1'b0;

  logic [7:0]   rdata16, rdata_q16, scan_data;
  logic [127:0] dump16;
  logic         scan_valid, scan_done;
  logic [3:0]   scan_idx;

  logic [7:0]   rdata12, rdata_q12, s12_data;
  logic [95:0]  dump12;
  logic         s12_valid, s12_done;
  logic [3:0]   s12_idx;

  int checks = 0;
  int errors = 0;

  logic [7:0] m16 [16];
  logic [7:0] m12 [12];
  logic [7:0] q16, q12;
  int         spos;   // -1 idle, 0..15 presenting word spos, 16 done cycle

  always #5 clock = ~clock;

  i281_datamem_n dut (
    .clock(clock), .reset(reset), .run(run), .we(we), .addr(addr), .wdata(wdata),
    .rd_en(rd_en), .rdata(rdata16), .rdata_q(rdata_q16), .dump(dump16),
    .scan_start(scan_start), .scan_valid(scan_valid), .scan_ready(scan_ready),
    .scan_data(scan_data), .scan_idx(scan_idx), .scan_done(scan_done)
  );

  i281_datamem_n #(.WIDTH(8), .DEPTH(12)) dut12 (
    .clock(clock), .reset(reset), .run(run), .we(we), .addr(addr), .wdata(wdata),
    .rd_en(rd_en), .rdata(rdata12), .rdata_q(rdata_q12), .dump(dump12),
    .scan_start(zero_l), .scan_valid(s12_valid), .scan_ready(zero_l),
    .scan_data(s12_data), .scan_idx(s12_idx), .scan_done(s12_done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] flat16();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = m16[i];
    return f;
  endfunction

  function automatic logic [127:0] flat12();
    logic [127:0] f = '0;
    for (int i = 0; i < 12; i++) f[i*8 +: 8] = m12[i];
    return f;
  endfunction

  function automatic logic [7:0] exp_rd12(input logic [3:0] a);
    logic [7:0] v = 8'h00;
    if (a < 4'd12) v = m12[a];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m16[i] = 8'h00;
    for (int i = 0; i < 12; i++) m12[i] = 8'h00;
    q16 = 8'h00; q12 = 8'h00; spos = -1;
  endtask

  task automatic post_checks();
    logic busy;
    chk("dump16", dump16, flat16());
    chk("dump12", {32'h0, dump12}, flat12());
    chk("rdata_q16", rdata_q16, q16);
    chk("rdata_q12", rdata_q12, q12);
    busy = (spos >= 0) && (spos < 16);
`ifdef DMEM_SCAN_EN
    chk("scan_valid", scan_valid, busy);
    chk("scan_done", scan_done, spos == 16);
    if (busy) begin
      chk("scan_idx", scan_idx, 4'(spos));
      chk("scan_data", scan_data, m16[spos]);
    end else if (spos < 0) begin
      chk("scan_idx_idle", scan_idx, 4'd0);
    end
`else
    chk("scan_tied", {scan_valid, scan_done, scan_idx, scan_data}, 14'h0);
`endif
  endtask

  // One clock: drive inputs, check combinational paths, advance the model, check state
  task automatic step(input logic r, input logic rn, input logic w, input logic [3:0] a,
                      input logic [7:0] d, input logic re, input logic ss, input logic sr);
    reset = r; run = rn; we = w; addr = a; wdata = d; rd_en = re;
    scan_start = ss; scan_ready = sr;
    #1;
    chk("rdata16", rdata16, m16[a]);
    chk("rdata12", rdata12, exp_rd12(a));
`ifdef DMEM_SCAN_EN
    if (spos >= 0 && spos < 16) chk("scan_data_pre", scan_data, m16[spos]);
`endif
    @(posedge clock);
    if (r) begin
      model_reset();
    end else begin
      if (rn) begin
        if (re) begin q16 = m16[a]; q12 = exp_rd12(a); end
        if (w) begin
          m16[a] = d;
          if (a < 4'd12) m12[a] = d;
        end
      end
`ifdef DMEM_SCAN_EN
      if (spos == -1) begin
        if (ss) spos = 0;
      end else if (spos == 16) spos = -1;
      else if (sr) spos = spos + 1;
`endif
    end
    #1;
    post_checks();
  endtask

  initial begin
    int got, done_at;
    logic [95:0] before12;
    reset = 1'b1; run = 1'b0; we = 1'b0; rd_en = 1'b0; addr = 4'd0; wdata = 8'h00;
    scan_start = 1'b0; scan_ready = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    chk("reset_dump16", dump16, 128'h0);
    chk("reset_dump12", {32'h0, dump12}, 128'h0);
    chk("reset_rdata_q", rdata_q16, 8'h00);
    chk("reset_scan_valid", scan_valid, 1'b0);
    post_checks();

    // Write, read back, then a gated write that must not land
    step(0, 1, 1, 4'd5, 8'hA7, 0, 0, 0);
    chk("dump_word5", dump16[47:40], 8'hA7);
    step(0, 1, 0, 4'd5, 8'h00, 1, 0, 0);
    chk("rdq_word5", rdata_q16, 8'hA7);
    step(0, 0, 1, 4'd5, 8'h11, 1, 0, 0);
    chk("run_gate_word5", dump16[47:40], 8'hA7);

    // Read-before-write on a shared address
    step(0, 1, 1, 4'd3, 8'h22, 0, 0, 0);
    step(0, 1, 1, 4'd3, 8'h99, 1, 0, 0);
    chk("rbw_rdata_q", rdata_q16, 8'h22);
    chk("rbw_mem3", dump16[31:24], 8'h99);

    // Out-of-range address on the 12-word instance
    before12 = dump12;
    step(0, 1, 1, 4'd13, 8'h5A, 0, 0, 0);
    chk("oor_no_write", {32'h0, dump12}, {32'h0, before12});
    #1 chk("oor_rdata", rdata12, 8'h00);

`ifdef DMEM_SCAN_EN
    // Full scan with ready held high; done must land on the 17th sampled cycle
    step(0, 0, 0, 4'd0, 8'h00, 0, 1, 1);
    got = 0; done_at = 0;
    for (int n = 2; n <= 40 && got == 0; n++) begin
      step(0, 0, 0, 4'd0, 8'h00, 0, 0, 1);
      if (scan_done === 1'b1) begin got = 1; done_at = n; end
    end
    chk("done_latency", done_at, 17);
    step(0, 0, 0, 4'd0, 8'h00, 0, 0, 1);
    chk("done_one_cycle", scan_done, 1'b0);

    // Back-pressure at index 4 with a write to the presented word, then reset at index 7
    step(0, 0, 0, 4'd0, 8'h00, 0, 1, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 4'd0, 8'h00, 0, 0, 1);
    chk("bp_at4", scan_idx, 4'd4);
    step(0, 0, 0, 4'd0, 8'h00, 0, 0, 0);
    step(0, 1, 1, 4'd4, 8'h5C, 0, 1, 0);
    step(0, 0, 0, 4'd0, 8'h00, 0, 0, 0);
    chk("bp_hold", scan_idx, 4'd4);
    chk("bp_live_data", scan_data, 8'h5C);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 4'd0, 8'h00, 0, 0, 1);
    chk("at7", scan_idx, 4'd7);
    step(1, 0, 0, 4'd0, 8'h00, 0, 0, 1);
    chk("rst_mid_valid", scan_valid, 1'b0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 4'd0, 8'h00, 0, 0, 1);
`endif

    // Randomised traffic, including occasional resets and scan requests
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)),
           8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
